// File: rtl/attn_pkg.sv
// Shared constants for the attention softmax datapath blocks.
package attn_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_LANES  = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bcast_lane_addsub.sv
// One lane of the broadcast add/subtract: W+1-bit exact result, then saturate or wrap.
module bcast_lane_addsub
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit SATURATE   = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  op_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  ovf_o
);

  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0] a_x;
  logic [DATA_WIDTH:0] b_x;
  logic [DATA_WIDTH:0] r;

  always_comb begin
    a_x   = {a_i[DATA_WIDTH-1], a_i};
    b_x   = {b_i[DATA_WIDTH-1], b_i};
    r     = (op_i == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    // The extra bit disagreeing with the sign bit means the W-bit result is out of range.
    ovf_o = r[DATA_WIDTH] ^ r[DATA_WIDTH-1];
    if (SATURATE && ovf_o) begin
      res_o = r[DATA_WIDTH] ? MAX_NEG : MAX_POS;
    end else begin
      res_o = r[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/bcast_addsub_pipe.sv
// Two-stage streaming a[i] +/- b broadcast stage with per-lane overflow and a sticky flag.
module bcast_addsub_pipe
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           b_in,
  input  logic                            b_load,
  input  logic                            op,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_ovf,
  output logic                            ovf_sticky,
  input  logic                            ovf_clr
);

  localparam int BW = NUM_LANES * DATA_WIDTH;

  // Handshake: a beat moves on a rising edge where valid && ready; a stage holds
  // its contents unchanged while it is valid and the next stage cannot take it.
  logic                  s1_valid_q, s1_valid_d;
  logic [BW-1:0]         s1_a_q, s1_a_d;
  logic                  s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [BW-1:0]         s2_data_q, s2_data_d;
  logic [NUM_LANES-1:0]  s2_ovf_q, s2_ovf_d;
  logic [DATA_WIDTH-1:0] b_reg_q, b_reg_d;
  logic                  sticky_q, sticky_d;

  logic                  s1_adv, s2_adv;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [BW-1:0]         lane_res;
  logic [NUM_LANES-1:0]  lane_ovf;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bcast_lane_addsub #(
      .DATA_WIDTH(DATA_WIDTH),
      .SATURATE  (SATURATE)
    ) u_lane (
      .a_i  (s1_a_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .b_i  (s1_b_q),
      .op_i (s1_op_q),
      .res_o(lane_res[i*DATA_WIDTH +: DATA_WIDTH]),
      .ovf_o(lane_ovf[i])
    );
  end

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    b_eff      = b_load ? b_in : b_reg_q;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_op_d    = s1_op_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    b_reg_d    = b_eff;
    sticky_d   = sticky_q;

    // b is frozen into S1 with its beat, so later b_load never touches beats in flight.
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = a_in;
        s1_op_d = op;
        s1_b_d  = b_eff;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lane_res;
        s2_ovf_d  = lane_ovf;
      end
    end

    if (ovf_clr) begin
      sticky_d = 1'b0;
    end else if (s2_valid_q && out_ready && (|s2_ovf_q)) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= '0;
      b_reg_q    <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_op_q    <= s1_op_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      b_reg_q    <= b_reg_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_ovf    = s2_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_bcast_addsub_pipe.sv
// Bench for bcast_addsub_pipe: saturating and wrapping instances share stimulus and a reference model.
module tb_bcast_addsub_pipe;

  localparam int W  = 16;
  localparam int NL = 4;
  localparam int DW = W * NL;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  b_in = '0;
  logic          b_load = 1'b0;
  logic          op = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic          out_ready = 1'b1;
  logic          ovf_clr = 1'b0;

  logic          in_ready_s, out_valid_s, sticky_s;
  logic [DW-1:0] out_data_s;
  logic [NL-1:0] out_ovf_s;
  logic          in_ready_w, out_valid_w, sticky_w;
  logic [DW-1:0] out_data_w;
  logic [NL-1:0] out_ovf_w;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bcast_addsub_pipe #(.DATA_WIDTH(W), .NUM_LANES(NL), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .b_in(b_in), .b_load(b_load), .op(op),
    .in_valid(in_valid), .in_ready(in_ready_s), .a_in(a_in),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_ovf(out_ovf_s), .ovf_sticky(sticky_s), .ovf_clr(ovf_clr)
  );

  bcast_addsub_pipe #(.DATA_WIDTH(W), .NUM_LANES(NL), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .b_in(b_in), .b_load(b_load), .op(op),
    .in_valid(in_valid), .in_ready(in_ready_w), .a_in(a_in),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .ovf_sticky(sticky_w), .ovf_clr(ovf_clr)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_beat(input logic [DW-1:0] a, input logic [W-1:0] b, input logic o,
                                   output logic [DW-1:0] rs, output logic [DW-1:0] rw,
                                   output logic [NL-1:0] ov);
    int sa, sb, r;
    int max_v, min_v;
    logic [W-1:0] low;
    max_v = (1 << (W-1)) - 1;
    min_v = -(1 << (W-1));
    sb = $signed(b);
    for (int i = 0; i < NL; i++) begin
      sa  = $signed(a[i*W +: W]);
      r   = o ? (sa - sb) : (sa + sb);
      low = r[W-1:0];
      ov[i] = (r > max_v) || (r < min_v);
      rw[i*W +: W] = low;
      if (r > max_v)      rs[i*W +: W] = max_v[W-1:0];
      else if (r < min_v) rs[i*W +: W] = min_v[W-1:0];
      else                rs[i*W +: W] = low;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] expw_q[$];
  logic [NL-1:0] expo_q[$];
  logic [W-1:0]  m_b = '0;
  logic          m_sticky = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    logic [DW-1:0] rs, rw, es, ew;
    logic [NL-1:0] ov, eo;
    logic          xfer_ovf;
    if (!rst) begin
      exp_q.delete(); expw_q.delete(); expo_q.delete();
      m_b = '0; m_sticky = 1'b0; prev_stall = 1'b0;
    end else begin
      check("sticky_sat", sticky_s, m_sticky);
      check("sticky_wrap", sticky_w, m_sticky);
      // Both stages full and output blocked is the only state that refuses input.
      check("in_ready", in_ready_s, !(exp_q.size() == 2 && !out_ready));
      check("in_ready_wrap", in_ready_w, !(exp_q.size() == 2 && !out_ready));
      if (prev_stall) check("stable_data", out_data_s, prev_data);
      xfer_ovf = 1'b0;
      if (out_valid_s && exp_q.size() == 0) check("spurious_out", 1, 0);
      if (out_valid_s && out_ready && exp_q.size() > 0) begin
        es = exp_q.pop_front(); ew = expw_q.pop_front(); eo = expo_q.pop_front();
        check("data_sat", out_data_s, es);
        check("ovf_sat", out_ovf_s, eo);
        check("valid_wrap", out_valid_w, 1);
        check("data_wrap", out_data_w, ew);
        check("ovf_wrap", out_ovf_w, eo);
        xfer_ovf = |eo;
      end
      if (ovf_clr) m_sticky = 1'b0;
      else if (xfer_ovf) m_sticky = 1'b1;
      if (in_valid && in_ready_s) begin
        ref_beat(a_in, b_load ? b_in : m_b, op, rs, rw, ov);
        exp_q.push_back(rs); expw_q.push_back(rw); expo_q.push_back(ov);
      end
      if (b_load) m_b = b_in;
      prev_stall = out_valid_s && !out_ready;
      prev_data  = out_data_s;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] a, input logic o, input logic bl, input logic [W-1:0] b);
    bit done;
    @(posedge clk); #1;
    a_in = a; op = o; b_load = bl; b_in = b; in_valid = 1'b1;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready_s) done = 1;
      @(posedge clk); #1;
      b_load = 1'b0;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid_s && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_valid_s, 1);
  endtask

  function automatic logic [W-1:0] pick_word();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc;
    bit got_it;
    logic [DW-1:0] a;

    // Reset held for 3 cycles
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_sticky", sticky_s, 0);
    check("rst_out_data", out_data_s, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready_s, 1);

    // Basic subtract
    send({16'hFFFF, 16'h0000, 16'h0005, 16'h0010}, 1'b1, 1'b1, 16'h0003);
    wait_valid("basic_valid");
    check("basic_data", out_data_s, 64'hFFFC_FFFD_0002_000D);
    check("basic_ovf", out_ovf_s, 0);

    // Positive and negative overflow, both modes
    send({16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b1, 1'b1, 16'hFFFF);
    wait_valid("ovfp_valid");
    check("ovfp_sat", out_data_s, 64'h0001_0001_0001_7FFF);
    check("ovfp_wrap", out_data_w, 64'h0001_0001_0001_8000);
    check("ovfp_flag", out_ovf_s, 4'b0001);
    send({16'h0000, 16'h0000, 16'h8000, 16'h0000}, 1'b1, 1'b1, 16'h0001);
    wait_valid("ovfn_valid");
    check("ovfn_sat", out_data_s, 64'hFFFF_FFFF_8000_FFFF);
    check("ovfn_wrap", out_data_w, 64'hFFFF_FFFF_7FFF_FFFF);
    check("ovfn_flag", out_ovf_w, 4'b0010);
    @(negedge clk);
    check("sticky_set", sticky_s, 1);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr", sticky_s, 0);

    // Backpressure: output blocked, input pushing
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a_in = {$urandom, $urandom}; op = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got_it = in_ready_s;
      if (got_it) acc++;
      @(posedge clk); #1;
      if (got_it) begin a_in = {$urandom, $urandom}; op = $urandom_range(0, 1); end
    end
    check("bp_accepted", acc, 2);
    @(negedge clk);
    check("bp_in_ready", in_ready_s, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); check("bp_out0", out_valid_s, 1);
    @(negedge clk); check("bp_out1", out_valid_s, 1);
    @(negedge clk); check("bp_out2", out_valid_s, 0);

    // b switch: new b used by same-cycle beat, later load leaves stalled beat alone
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = 1'b1; b_load = 1'b1; b_in = 16'h0010;
    a_in = {16'h0000, 16'h0000, 16'h0000, 16'h0020};
    @(negedge clk); check("bsw_accept", in_ready_s, 1);
    @(posedge clk); #1; in_valid = 1'b0; b_load = 1'b0;
    @(posedge clk); #1; b_load = 1'b1; b_in = 16'h0005;
    @(posedge clk); #1; b_load = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bsw_valid", out_valid_s, 1);
    check("bsw_data", out_data_s, 64'hFFF0_FFF0_FFF0_0010);

    // Mid-stream reset with two beats in flight
    send({16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b1, 1'b1, 16'hFFFF);
    wait_valid("mr_pre_valid");
    @(posedge clk); #1; out_ready = 1'b0;
    send({$urandom, $urandom}, 1'b0, 1'b1, 16'h1234);
    send({$urandom, $urandom}, 1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mr_out_valid", out_valid_s, 0);
    check("mr_sticky", sticky_s, 0);
    send({4{16'h0007}}, 1'b0, 1'b0, 16'h0000);
    wait_valid("mr_post_valid");
    check("mr_post_data", out_data_s, {4{16'h0007}});
    check("mr_post_ovf", out_ovf_s, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NL; i++) a[i*W +: W] = pick_word();
      a_in      = a;
      op        = $urandom_range(0, 1);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      b_load    = ($urandom_range(0, 5) == 0);
      b_in      = pick_word();
      ovf_clr   = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; b_load = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
